// File: rtl/tpu_host_seq.sv
// Host-side sequencer for the matrix accelerator: buffers an A/B tile, launches it as one
// contiguous burst, captures the unthrottled result burst and replays it under backpressure.
module tpu_host_seq #(
   parameter int ROWS    = 32,
   parameter int WORD    = 256,
   parameter int TIMEOUT = 4096
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [4:0]      cmd_m,
   input  logic [4:0]      cmd_n,
   input  logic [4:0]      cmd_k,
   input  logic            row_valid,
   output logic            row_ready,
   input  logic [WORD-1:0] row_a,
   input  logic [WORD-1:0] row_b,
   output logic            acc_in_valid,
   output logic [WORD-1:0] acc_a,
   output logic [WORD-1:0] acc_b,
   output logic [4:0]      acc_m,
   output logic [4:0]      acc_n,
   output logic [4:0]      acc_k,
   input  logic            acc_out_valid,
   input  logic [WORD-1:0] acc_out,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [WORD-1:0] res_data,
   output logic            res_last,
   output logic            busy,
   output logic            err,
   output logic [2:0]      state_dbg
);

   // Handshakes: a beat transfers on a rising edge where valid && ready are both high;
   // valid is never withdrawn and its payload never changes until that edge.

   localparam int AW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW  = $clog2(ROWS) + 1;
   localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0]  LAST   = CW'(ROWS - 1);
   localparam logic [WDW-1:0] WD_LIM = WDW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FILL   = 3'd1,
      S_LAUNCH = 3'd2,
      S_WAIT   = 3'd3,
      S_DRAIN  = 3'd4
   } state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n, cnt_inc;
   logic [WDW-1:0]  wd, wd_n;
   logic [AW-1:0]   idx, inc_idx;
   logic            fill_we, res_we;

   logic [WORD-1:0] rowbuf_a [ROWS];
   logic [WORD-1:0] rowbuf_b [ROWS];
   logic [WORD-1:0] resbuf   [ROWS];

   logic            cmd_ready_n, row_ready_n, acc_in_valid_n, res_valid_n, res_last_n;
   logic            busy_n, err_n;
   logic [WORD-1:0] acc_a_n, acc_b_n, res_data_n;
   logic [4:0]      acc_m_n, acc_n_n, acc_k_n;

   assign cnt_inc   = cnt + CW'(1);
   assign idx       = cnt[AW-1:0];
   assign inc_idx   = cnt_inc[AW-1:0];
   assign state_dbg = state;

   always_comb begin
      state_n        = state;
      cnt_n          = cnt;
      wd_n           = wd;
      cmd_ready_n    = cmd_ready;
      row_ready_n    = row_ready;
      acc_in_valid_n = acc_in_valid;
      acc_a_n        = acc_a;
      acc_b_n        = acc_b;
      acc_m_n        = acc_m;
      acc_n_n        = acc_n;
      acc_k_n        = acc_k;
      res_valid_n    = res_valid;
      res_data_n     = res_data;
      res_last_n     = res_last;
      busy_n         = busy;
      err_n          = err;
      fill_we        = 1'b0;
      res_we         = 1'b0;

      // Results arriving outside WAIT cannot be stored anywhere meaningful.
      if (acc_out_valid && state != S_WAIT) err_n = 1'b1;

      case (state)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               state_n     = S_FILL;
               cnt_n       = '0;
               acc_m_n     = cmd_m;
               acc_n_n     = cmd_n;
               acc_k_n     = cmd_k;
               err_n       = acc_out_valid;
               cmd_ready_n = 1'b0;
               row_ready_n = 1'b1;
               busy_n      = 1'b1;
            end
         end
         S_FILL: begin
            if (row_valid && row_ready) begin
               fill_we = 1'b1;
               if (cnt == LAST) begin
                  state_n        = S_LAUNCH;
                  cnt_n          = '0;
                  row_ready_n    = 1'b0;
                  acc_in_valid_n = 1'b1;
                  // Entry 0 is still in flight when the tile is a single row.
                  acc_a_n        = (ROWS == 1) ? row_a : rowbuf_a[0];
                  acc_b_n        = (ROWS == 1) ? row_b : rowbuf_b[0];
               end else begin
                  cnt_n = cnt_inc;
               end
            end
         end
         S_LAUNCH: begin
            if (cnt == LAST) begin
               state_n        = S_WAIT;
               cnt_n          = '0;
               wd_n           = '0;
               acc_in_valid_n = 1'b0;
               acc_a_n        = '0;
               acc_b_n        = '0;
            end else begin
               cnt_n   = cnt_inc;
               acc_a_n = rowbuf_a[inc_idx];
               acc_b_n = rowbuf_b[inc_idx];
            end
         end
         S_WAIT: begin
            wd_n = wd + WDW'(1);
            if (acc_out_valid) begin
               res_we = 1'b1;
               cnt_n  = cnt_inc;
            end
            if (acc_out_valid && cnt == LAST) begin
               state_n     = S_DRAIN;
               cnt_n       = '0;
               res_valid_n = 1'b1;
               res_data_n  = (ROWS == 1) ? acc_out : resbuf[0];
               res_last_n  = (ROWS == 1);
            end else if (TIMEOUT != 0 && wd_n == WD_LIM) begin
               state_n     = S_IDLE;
               cnt_n       = '0;
               err_n       = 1'b1;
               cmd_ready_n = 1'b1;
               busy_n      = 1'b0;
            end
         end
         S_DRAIN: begin
            if (res_ready) begin
               if (cnt == LAST) begin
                  state_n     = S_IDLE;
                  cnt_n       = '0;
                  res_valid_n = 1'b0;
                  res_last_n  = 1'b0;
                  res_data_n  = '0;
                  cmd_ready_n = 1'b1;
                  busy_n      = 1'b0;
               end else begin
                  cnt_n      = cnt_inc;
                  res_data_n = resbuf[inc_idx];
                  res_last_n = (cnt_inc == LAST);
               end
            end
         end
         default: begin
            state_n     = S_IDLE;
            cmd_ready_n = 1'b1;
            busy_n      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         wd           <= '0;
         cmd_ready    <= 1'b1;
         row_ready    <= 1'b0;
         acc_in_valid <= 1'b0;
         acc_a        <= '0;
         acc_b        <= '0;
         acc_m        <= '0;
         acc_n        <= '0;
         acc_k        <= '0;
         res_valid    <= 1'b0;
         res_data     <= '0;
         res_last     <= 1'b0;
         busy         <= 1'b0;
         err          <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         wd           <= wd_n;
         cmd_ready    <= cmd_ready_n;
         row_ready    <= row_ready_n;
         acc_in_valid <= acc_in_valid_n;
         acc_a        <= acc_a_n;
         acc_b        <= acc_b_n;
         acc_m        <= acc_m_n;
         acc_n        <= acc_n_n;
         acc_k        <= acc_k_n;
         res_valid    <= res_valid_n;
         res_data     <= res_data_n;
         res_last     <= res_last_n;
         busy         <= busy_n;
         err          <= err_n;
      end
   end

   // Buffer contents are never reset; only the counters decide what is valid.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         rowbuf_a[idx] <= row_a;
         rowbuf_b[idx] <= row_b;
      end
      if (res_we) resbuf[idx] <= acc_out;
   end

endmodule

// File: tb/tb_tpu_host_seq.sv
// Scenario bench for tpu_host_seq: load bursts, result replay under backpressure,
// watchdog abort, stray-result error and mid-burst reset.
module tb_tpu_host_seq;

   localparam int ROWS    = 32;
   localparam int WORD    = 32;
   localparam int TIMEOUT = 100;

   logic            clk = 1'b0;
   logic            rst;
   logic            cmd_valid, cmd_ready;
   logic [4:0]      cmd_m, cmd_n, cmd_k;
   logic            row_valid, row_ready;
   logic [WORD-1:0] row_a, row_b;
   logic            acc_in_valid;
   logic [WORD-1:0] acc_a, acc_b;
   logic [4:0]      acc_m, acc_n, acc_k;
   logic            acc_out_valid;
   logic [WORD-1:0] acc_out;
   logic            res_valid, res_ready, res_last;
   logic [WORD-1:0] res_data;
   logic            busy, err;
   logic [2:0]      state_dbg;

   int checks = 0;
   int errors = 0;

   logic [WORD-1:0] exp_a_q[$];
   logic [WORD-1:0] exp_b_q[$];
   logic [WORD-1:0] exp_q[$];

   tpu_host_seq #(.ROWS(ROWS), .WORD(WORD), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_k(cmd_k),
      .row_valid(row_valid), .row_ready(row_ready), .row_a(row_a), .row_b(row_b),
      .acc_in_valid(acc_in_valid), .acc_a(acc_a), .acc_b(acc_b),
      .acc_m(acc_m), .acc_n(acc_n), .acc_k(acc_k),
      .acc_out_valid(acc_out_valid), .acc_out(acc_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
      .busy(busy), .err(err), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // driver tasks
   task automatic send_cmd(input logic [4:0] m, input logic [4:0] n, input logic [4:0] k);
      int t = 0;
      while (cmd_ready !== 1'b1 && t < 50) begin step(); t++; end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
      end
      cmd_valid = 1'b1; cmd_m = m; cmd_n = n; cmd_k = k;
      step();
      cmd_valid = 1'b0;
      checks++;
      if (acc_m !== m || acc_n !== n || acc_k !== k) begin
         errors++; $display("FAIL cmd_dims: got %0d/%0d/%0d want %0d/%0d/%0d", acc_m, acc_n, acc_k, m, n, k);
      end
      checks++;
      if (err !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0 || row_ready !== 1'b1) begin
         errors++;
         $display("FAIL cmd_accept: got err=%b busy=%b cmd_ready=%b row_ready=%b want 0 1 0 1", err, busy, cmd_ready, row_ready);
      end
   endtask

   task automatic fill_rows(input bit gaps);
      int i = 0;
      int t = 0;
      logic [WORD-1:0] v;
      while (i < ROWS && t < 500) begin
         checks++;
         if (row_ready !== 1'b1 || acc_in_valid !== 1'b0) begin
            errors++; $display("FAIL fill_ready: got row_ready=%b acc_in_valid=%b want 1 0", row_ready, acc_in_valid);
         end
         row_valid = gaps ? (t % 2 == 0) : 1'b1;
         v = WORD'(i);
         row_a = v;
         row_b = ~v;
         if (row_valid) begin
            exp_a_q.push_back(v);
            exp_b_q.push_back(~v);
            i++;
         end
         step();
         t++;
      end
      row_valid = 1'b0;
      checks++;
      if (row_ready !== 1'b0 || acc_in_valid !== 1'b1) begin
         errors++; $display("FAIL fill_to_launch: got row_ready=%b acc_in_valid=%b want 0 1", row_ready, acc_in_valid);
      end
   endtask

   task automatic launch(input int nbeats, input logic [4:0] m);
      logic [WORD-1:0] ea, eb;
      for (int j = 0; j < nbeats; j++) begin
         ea = (exp_a_q.size() > 0) ? exp_a_q.pop_front() : '0;
         eb = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : '0;
         checks++;
         if (acc_in_valid !== 1'b1 || acc_a !== ea || acc_b !== eb || acc_m !== m || row_ready !== 1'b0) begin
            errors++;
            $display("FAIL launch_beat%0d: got v=%b a=%h b=%h m=%0d rr=%b want 1 %h %h %0d 0",
                     j, acc_in_valid, acc_a, acc_b, acc_m, row_ready, ea, eb, m);
         end
         step();
      end
      if (nbeats == ROWS) begin
         checks++;
         if (acc_in_valid !== 1'b0 || acc_a !== '0 || acc_b !== '0) begin
            errors++; $display("FAIL launch_end: got v=%b a=%h b=%h want 0 0 0", acc_in_valid, acc_a, acc_b);
         end
      end
   endtask

   task automatic return_results(input int delay);
      for (int d = 0; d < delay; d++) begin
         checks++;
         if (res_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL wait_idle: got res_valid=%b busy=%b want 0 1", res_valid, busy);
         end
         step();
      end
      for (int i = 0; i < ROWS; i++) begin
         acc_out_valid = 1'b1;
         acc_out = WORD'(i * 3);
         exp_q.push_back(WORD'(i * 3));
         step();
      end
      acc_out_valid = 1'b0;
      acc_out = '0;
   endtask

   task automatic drain(input int pct, input logic [4:0] m);
      int beat = 0;
      int t = 0;
      bit have_prev = 1'b0;
      bit rdy;
      logic [WORD-1:0] prev_data, e;
      logic prev_last;
      while (beat < ROWS && t < 2000) begin
         rdy = ($urandom_range(99, 0) < pct);
         checks++;
         if (res_valid !== 1'b1) begin
            errors++; $display("FAIL drain_valid: got %b want 1 at beat %0d", res_valid, beat);
         end
         if (have_prev) begin
            checks++;
            if (res_data !== prev_data || res_last !== prev_last) begin
               errors++; $display("FAIL drain_stall: got %h/%b want %h/%b", res_data, res_last, prev_data, prev_last);
            end
         end
         if (rdy) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks++;
            if (res_data !== e || res_last !== (beat == ROWS - 1)) begin
               errors++;
               $display("FAIL drain_beat%0d: got %h last=%b want %h last=%b", beat, res_data, res_last, e, beat == ROWS - 1);
            end
            beat++;
            have_prev = 1'b0;
         end else begin
            have_prev = 1'b1;
            prev_data = res_data;
            prev_last = res_last;
         end
         res_ready = rdy;
         step();
         t++;
      end
      res_ready = 1'b0;
      checks++;
      if (beat != ROWS) begin
         errors++; $display("FAIL drain_count: got %0d want %0d", beat, ROWS);
      end
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || res_last !== 1'b0 || cmd_ready !== 1'b1 || acc_m !== m) begin
         errors++;
         $display("FAIL drain_done: got busy=%b rv=%b rl=%b cr=%b m=%0d want 0 0 0 1 %0d", busy, res_valid, res_last, cmd_ready, acc_m, m);
      end
   endtask

   // scenarios
   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (cmd_ready !== 1'b1 || row_ready !== 1'b0 || acc_in_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got cr=%b rr=%b av=%b busy=%b err=%b want 1 0 0 0 0", cmd_ready, row_ready, acc_in_valid, busy, err);
      end
      checks++;
      if (acc_a !== '0 || acc_b !== '0 || acc_m !== 5'd0 || acc_n !== 5'd0 || acc_k !== 5'd0) begin
         errors++; $display("FAIL reset_acc: got a=%h b=%h m=%0d n=%0d k=%0d want zeros", acc_a, acc_b, acc_m, acc_n, acc_k);
      end
      checks++;
      if (res_valid !== 1'b0 || res_data !== '0 || res_last !== 1'b0 || state_dbg !== 3'd0) begin
         errors++; $display("FAIL reset_res: got rv=%b rd=%h rl=%b st=%0d want 0 0 0 0", res_valid, res_data, res_last, state_dbg);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      send_cmd(5'd16, 5'd16, 5'd16);
      fill_rows(1'b0);
      launch(ROWS, 5'd16);
      return_results(4);
      drain(100, 5'd16);
   endtask

   task automatic test_gapped_backpressure();
      send_cmd(5'd7, 5'd9, 5'd11);
      fill_rows(1'b1);
      launch(ROWS, 5'd7);
      return_results(1);
      drain(30, 5'd7);
   endtask

   task automatic test_timeout();
      int n = 0;
      send_cmd(5'd3, 5'd4, 5'd5);
      fill_rows(1'b0);
      launch(ROWS, 5'd3);
      while (err !== 1'b1 && n < 300) begin step(); n++; end
      checks++;
      if (n != TIMEOUT) begin
         errors++; $display("FAIL timeout_cycles: got %0d want %0d", n, TIMEOUT);
      end
      checks++;
      if (state_dbg !== 3'd0 || cmd_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL timeout_state: got st=%0d cr=%b busy=%b rv=%b want 0 1 0 0", state_dbg, cmd_ready, busy, res_valid);
      end
      send_cmd(5'd1, 5'd2, 5'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_stray_result();
      acc_out_valid = 1'b1;
      acc_out = 32'hdead;
      step();
      acc_out_valid = 1'b0;
      checks++;
      if (err !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL stray_err: got err=%b cr=%b busy=%b want 1 1 0", err, cmd_ready, busy);
      end
      send_cmd(5'd2, 5'd2, 5'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_launch();
      send_cmd(5'd12, 5'd13, 5'd14);
      fill_rows(1'b0);
      launch(10, 5'd12);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_a_q.delete();
      exp_b_q.delete();
      checks++;
      if (acc_in_valid !== 1'b0 || acc_a !== '0 || acc_b !== '0 || acc_m !== 5'd0 || cmd_ready !== 1'b1 ||
          row_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || res_valid !== 1'b0 || state_dbg !== 3'd0) begin
         errors++;
         $display("FAIL midreset_outputs: got av=%b a=%h m=%0d cr=%b rr=%b busy=%b err=%b rv=%b st=%0d want reset values",
                  acc_in_valid, acc_a, acc_m, cmd_ready, row_ready, busy, err, res_valid, state_dbg);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (acc_in_valid !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_quiet: got av=%b rv=%b want 0 0", acc_in_valid, res_valid);
         end
         step();
      end
      send_cmd(5'd16, 5'd8, 5'd4);
      fill_rows(1'b0);
      launch(ROWS, 5'd16);
      return_results(2);
      drain(60, 5'd16);
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_m = '0; cmd_n = '0; cmd_k = '0;
      row_valid = 1'b0; row_a = '0; row_b = '0;
      acc_out_valid = 1'b0; acc_out = '0;
      res_ready = 1'b0;
      test_reset();
      test_back_to_back();
      test_gapped_backpressure();
      test_timeout();
      test_stray_result();
      test_reset_mid_launch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
